// File: rtl/rf_scoreboard_pkg.sv
// Shared sizing constants for the register-file hazard scoreboard.
package rf_scoreboard_pkg;
  localparam int NREG        = 8;
  localparam int SEL_W       = 3;
  localparam int CNT_W       = 2;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;
  localparam int STALL_CNT_W = 16;
endpackage

// File: rtl/rf_scoreboard_sb_cnt.sv
// One saturating up/down counter of in-flight writes to a single register.
module sb_cnt #(
  parameter int W = rf_scoreboard_pkg::CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  output logic zero,
  output logic one,
  output logic full,
  output logic underflow
);
  import rf_scoreboard_pkg::*;

  logic [W-1:0] cnt_q, cnt_d;

  assign zero      = (cnt_q == '0);
  assign one       = (cnt_q == W'(1));
  assign full      = (cnt_q == '1);
  // A writeback to an idle register is a protocol error unless it is being squashed.
  assign underflow = dec & zero & ~clr;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && !dec && !full)
      cnt_d = cnt_q + W'(1);
    else if (dec && !inc && !zero)
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end
endmodule

// File: rtl/rf_scoreboard.sv
// Issue-side hazard controller: per-register pending-write counters, stall generation and stall statistics.
module rf_scoreboard #(
  parameter int NREG  = rf_scoreboard_pkg::NREG,
  parameter int CNT_W = rf_scoreboard_pkg::CNT_W
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    id_valid,
  input  logic [$clog2(NREG)-1:0]                 id_src1_sel,
  input  logic [$clog2(NREG)-1:0]                 id_src2_sel,
  input  logic                                    id_src1_used,
  input  logic                                    id_src2_used,
  input  logic [$clog2(NREG)-1:0]                 id_dst_sel,
  input  logic                                    id_dst_wr,
  input  logic                                    wb_en,
  input  logic [$clog2(NREG)-1:0]                 wb_sel,
  input  logic                                    flush,
  output logic                                    stall,
  output logic                                    issue,
  output logic [NREG-1:0]                         busy,
  output logic [rf_scoreboard_pkg::STALL_CNT_W-1:0] stall_cnt,
  output logic                                    err
);
  import rf_scoreboard_pkg::*;

  localparam int SW = $clog2(NREG);

  logic [NREG-1:0] zero_w, one_w, full_w, uflow_w;
  logic            src1_haz, src2_haz, dst_haz;
  logic            err_q, err_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_cnt
      localparam logic [SW-1:0] IDX = SW'(gi);
      sb_cnt #(.W(CNT_W)) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .inc       (issue & id_dst_wr & (id_dst_sel == IDX)),
        .dec       (wb_en & ~flush & (wb_sel == IDX)),
        .clr       (flush),
        .zero      (zero_w[gi]),
        .one       (one_w[gi]),
        .full      (full_w[gi]),
        .underflow (uflow_w[gi])
      );
    end
  endgenerate

  // A single outstanding write retiring this cycle is forwarded by the register-file wrapper.
  assign src1_haz = id_src1_used & ~zero_w[id_src1_sel]
                  & ~(one_w[id_src1_sel] & wb_en & (wb_sel == id_src1_sel));
  assign src2_haz = id_src2_used & ~zero_w[id_src2_sel]
                  & ~(one_w[id_src2_sel] & wb_en & (wb_sel == id_src2_sel));
  assign dst_haz  = id_dst_wr & full_w[id_dst_sel]
                  & ~(wb_en & (wb_sel == id_dst_sel));

  assign stall = rst & id_valid & ~flush & (src1_haz | src2_haz | dst_haz);
  assign issue = rst & id_valid & ~flush & ~stall;
  assign busy  = ~zero_w;

  always_comb begin
    err_d       = err_q | (|uflow_w);
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign err       = err_q;
  assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed bench for rf_scoreboard: dependency stalls, saturation, underflow, flush, reset and stall counting.
module tb_rf_scoreboard;
  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [2:0]  id_src1_sel, id_src2_sel, id_dst_sel, wb_sel;
  logic        id_src1_used, id_src2_used, id_dst_wr, wb_en, flush;
  logic        stall, issue, err;
  logic [7:0]  busy;
  logic [15:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  rf_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_src1_sel  (id_src1_sel),
    .id_src2_sel  (id_src2_sel),
    .id_src1_used (id_src1_used),
    .id_src2_used (id_src2_used),
    .id_dst_sel   (id_dst_sel),
    .id_dst_wr    (id_dst_wr),
    .wb_en        (wb_en),
    .wb_sel       (wb_sel),
    .flush        (flush),
    .stall        (stall),
    .issue        (issue),
    .busy         (busy),
    .stall_cnt    (stall_cnt),
    .err          (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    id_valid     = 1'b0;
    id_src1_sel  = 3'd0;
    id_src2_sel  = 3'd0;
    id_src1_used = 1'b0;
    id_src2_used = 1'b0;
    id_dst_sel   = 3'd0;
    id_dst_wr    = 1'b0;
    wb_en        = 1'b0;
    wb_sel       = 3'd0;
    flush        = 1'b0;
  endtask

  task automatic wr_dst(input logic [2:0] r);
    idle();
    id_valid   = 1'b1;
    id_dst_wr  = 1'b1;
    id_dst_sel = r;
  endtask

  initial begin
    // Reset with an issuable instruction presented: nothing may issue or be tracked.
    rst = 1'b0;
    idle();
    tick();
    tick();
    wr_dst(3'd3);
    settle();
    chk("rst_stall", stall, 1'b0);
    chk("rst_issue", issue, 1'b0);
    chk("rst_busy", busy, 8'h00);
    chk("rst_stall_cnt", stall_cnt, 16'h0000);
    chk("rst_err", err, 1'b0);
    tick();
    chk("rst_busy_after_edge", busy, 8'h00);

    // Back-to-back dependency on r3.
    rst = 1'b1;
    wr_dst(3'd3);
    settle();
    chk("b2b_prod_issue", issue, 1'b1);
    tick();
    idle();
    id_valid = 1'b1; id_src1_used = 1'b1; id_src1_sel = 3'd3;
    settle();
    chk("b2b_stall", stall, 1'b1);
    chk("b2b_issue_held", issue, 1'b0);
    chk("b2b_busy", busy, 8'h08);
    tick();
    wb_en = 1'b1; wb_sel = 3'd3;
    settle();
    chk("b2b_wb_stall", stall, 1'b0);
    chk("b2b_wb_issue", issue, 1'b1);
    chk("b2b_wb_busy", busy, 8'h08);
    tick();
    idle();
    settle();
    chk("b2b_busy_clear", busy, 8'h00);
    chk("b2b_stall_cnt", stall_cnt, 16'd1);

    // Saturate r5 at three in-flight writes.
    repeat (3) begin
      wr_dst(3'd5);
      tick();
    end
    settle();
    chk("sat_busy", busy, 8'h20);
    wr_dst(3'd5);
    settle();
    chk("sat_dst_stall", stall, 1'b1);
    wb_en = 1'b1; wb_sel = 3'd5;
    settle();
    chk("sat_incdec_stall", stall, 1'b0);
    chk("sat_incdec_issue", issue, 1'b1);
    tick();
    wb_en = 1'b0;
    settle();
    chk("sat_still_full", stall, 1'b1);
    // Drain to two; forwarding must not apply while more than one write is pending.
    idle();
    wb_en = 1'b1; wb_sel = 3'd5;
    tick();
    id_valid = 1'b1; id_src1_used = 1'b1; id_src1_sel = 3'd5;
    settle();
    chk("cnt2_wb_no_fwd", stall, 1'b1);
    id_valid = 1'b0;
    tick();
    idle();
    id_valid = 1'b1; id_src1_used = 1'b1; id_src1_sel = 3'd5;
    settle();
    chk("cnt1_stall", stall, 1'b1);
    wb_en = 1'b1; wb_sel = 3'd5;
    settle();
    chk("cnt1_fwd_stall", stall, 1'b0);
    chk("cnt1_fwd_issue", issue, 1'b1);
    tick();
    idle();
    settle();
    chk("sat_drained_busy", busy, 8'h00);
    chk("sat_stall_cnt", stall_cnt, 16'd1);
    chk("sat_err", err, 1'b0);

    // Flush with r1 and r6 pending, a writeback to r1 and a masked hazard on r6.
    wr_dst(3'd1);
    tick();
    wr_dst(3'd6);
    tick();
    idle();
    settle();
    chk("flush_pre_busy", busy, 8'h42);
    wr_dst(3'd2);
    id_src1_used = 1'b1; id_src1_sel = 3'd6;
    flush = 1'b1; wb_en = 1'b1; wb_sel = 3'd1;
    settle();
    chk("flush_issue", issue, 1'b0);
    chk("flush_stall", stall, 1'b0);
    tick();
    idle();
    settle();
    chk("flush_busy", busy, 8'h00);
    chk("flush_err", err, 1'b0);
    flush = 1'b1; wb_en = 1'b1; wb_sel = 3'd4;
    tick();
    idle();
    settle();
    chk("flush_wb_idle_err", err, 1'b0);

    // Underflow on idle r2.
    wb_en = 1'b1; wb_sel = 3'd2;
    tick();
    idle();
    settle();
    chk("uflow_err", err, 1'b1);
    chk("uflow_busy", busy, 8'h00);
    tick();
    chk("uflow_err_sticky", err, 1'b1);
    id_valid = 1'b1; id_src1_used = 1'b1; id_src1_sel = 3'd2;
    settle();
    chk("uflow_r2_idle", stall, 1'b0);

    // Reset mid-stall on r0.
    wr_dst(3'd0);
    tick();
    idle();
    id_valid = 1'b1; id_src2_used = 1'b1; id_src2_sel = 3'd0;
    settle();
    chk("rms_stall", stall, 1'b1);
    chk("rms_busy", busy, 8'h01);
    tick();
    chk("rms_stall_cnt", stall_cnt, 16'd2);
    rst = 1'b0;
    wb_en = 1'b1; wb_sel = 3'd3;
    settle();
    chk("rms_rst_stall", stall, 1'b0);
    chk("rms_rst_issue", issue, 1'b0);
    tick();
    rst = 1'b1;
    idle();
    settle();
    chk("rms_busy_clr", busy, 8'h00);
    chk("rms_stall_cnt_clr", stall_cnt, 16'd0);
    chk("rms_err_clr", err, 1'b0);

    // Stall counter saturation with a persistent hazard on r7.
    wr_dst(3'd7);
    tick();
    idle();
    id_valid = 1'b1; id_src1_used = 1'b1; id_src1_sel = 3'd7;
    repeat (10) tick();
    chk("scnt_10", stall_cnt, 16'd10);
    repeat (65530) tick();
    chk("scnt_sat", stall_cnt, 16'hFFFF);
    chk("scnt_still_stall", stall, 1'b1);
    repeat (3) tick();
    chk("scnt_hold", stall_cnt, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rf_scoreboard.md
# rf_scoreboard

Issue-side hazard controller for the 8x16b bypassed register file. Tracks in-flight writes per architectural register with small saturating counters, raises `stall` toward decode when an instruction reads a register whose write has not reached the register file, and retires entries as writebacks occur. It sits between decode and the register-file wrapper; its writeback inputs are driven by the same signals that drive the register-file write port.

## Interface
Parameters:
- `NREG`, 8: number of architectural registers; the select width is log2(`NREG`), i.e. 3.
- `CNT_W`, 2: width of each pending-write counter; the maximum number of in-flight writes per register is 2^`CNT_W`-1 (3).

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset (0 = reset, sampled on the rising `clk` edge).
- `id_valid`  in  1  decode presents an instruction.
- `id_src1_sel` / `id_src2_sel`  in  3 each  source register selects.
- `id_src1_used` / `id_src2_used`  in  1 each  source is actually read.
- `id_dst_sel`  in  3  destination register select.
- `id_dst_wr`  in  1  instruction writes `id_dst_sel`.
- `wb_en`  in  1  register-file write enable this cycle.
- `wb_sel`  in  3  register-file write select this cycle.
- `flush`  in  1  squash all in-flight instructions.
- `stall`  out  1  decode must hold; the instruction does not issue.
- `issue`  out  1  `id_valid & ~stall & ~flush`.
- `busy`  out  8  bit i is 1 when counter i is nonzero.
- `stall_cnt`  out  16  saturating count of cycles with `id_valid & stall`.
- `err`  out  1  sticky protocol-error flag.

## Operation
- Counter i next value = cnt[i] + inc_i - dec_i, where:
  - inc_i = `issue & id_dst_wr & (id_dst_sel==i)`
  - dec_i = `wb_en & (wb_sel==i)`
- Simultaneous inc_i and dec_i on the same register leaves cnt[i] unchanged.
- Source hazard on srcN = `id_srcN_used & cnt[sel]!=0`, except when `cnt[sel]==1 & wb_en & wb_sel==sel`. In that case the register-file wrapper forwards the write data, so there is no hazard.
- Destination hazard = `id_dst_wr & cnt[id_dst_sel]==max & ~(wb_en & wb_sel==id_dst_sel)`.
- `stall = id_valid & ~flush & (src1 hazard | src2 hazard | dst hazard)`.
- Underflow: if `wb_en` targets a register whose counter is 0, the counter stays 0 and `err` is set.
- `err` is sticky until reset.
- `flush` has priority over everything else:
  - all counters clear to 0 on the next edge;
  - `issue` is forced to 0;
  - writebacks in the same cycle are ignored and cannot set `err`.
- `stall_cnt` increments on each cycle with `id_valid & stall` and holds at 16'hFFFF.
- Register index 0 is an ordinary register with no special treatment.

## Timing
- Reset values: all counters 0, `busy` = 8'h00, `stall_cnt` = 0, `err` = 0.
- `stall` and `issue` are 0 during reset.
- `stall` and `issue` are combinational from the current inputs and counters. There is zero-cycle latency from a writeback to the release of a stall.
- Counters, `busy`, `stall_cnt` and `err` are registered. An issued write makes `busy` visible on the cycle after the issue edge.
- A dependent instruction presented the cycle after its producer issued sees the hazard immediately.
- Reset asserted mid-operation discards all pending state on that edge, regardless of `flush` or `wb_en`.
- Decode must hold its inputs stable while `stall` = 1; the block does not latch them.

## Structure
- Shared package holds: `NREG`, `SEL_W` = 3, `CNT_W`, `CNT_MAX`, and the `stall_cnt` width.
- One sub-module, `sb_cnt`: a single per-register up/down counter.
  - Inputs: `inc`, `dec`, `clr`.
  - Outputs: `zero`, `one`, `full`, `underflow`.
  - Instantiated `NREG` times.
- Hazard comparison and `stall_cnt` live in the top level.

## Test plan
- **Back-to-back dependency.** Cycle 0: issue dst=r3; cycle 1: src1=r3 with no writeback → `stall`=1, `busy`=8'h08. Later `wb_en`, `wb_sel`=3 → `stall`=0 and `issue`=1 in that same cycle; `busy` clears next cycle.
- **Same-cycle inc/dec and saturation.** Issue three writes to r5 → fourth write to r5 stalls. Fourth write with `wb_sel`=5 in the same cycle → issues, and the counter stays at 3.
- **Underflow.** `wb_en`, `wb_sel`=2 with r2 idle → `err`=1 next cycle and stays 1; counter 2 remains 0.
- **Flush.** r1 and r6 pending, `flush`=1 with `wb_en` on r1 → `issue`=0; next cycle `busy`=0 and `err`=0.
- **Reset mid-stall.** `rst`=0 while stalled with counters nonzero → next cycle all outputs are at reset values, including `stall_cnt`=0.
- **Stall counter saturation.** Hold `id_valid` with a hazard for 65540 cycles → `stall_cnt` = 16'hFFFF and holds.
